weight_fetch_unit: RTL
======================

# weight_fetch_unit

Parametrised weight fetch engine for one output channel, handling any input-channel count and selectable kernel phases. It issues word reads to the memory arbiter for the 3x3 kernel, then the 1x1 kernel, or either alone. Returned words are written into the MAC-array weight buffer with a structured address. It sits between the layer controller and the arbiter, and limits the number of outstanding reads.

## Interface
- DATA_W, 32: bus data width; WPW = DATA_W/8 int8 weights per word
- ADDR_W, 32: bus address width
- MAX_ICH, 256: largest supported input-channel count, power of two
- MAX_OUTST, 8: maximum outstanding read requests, 1..16
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle start pulse, honoured only when idle
- mode  in  2  00/11 = 3x3 then 1x1; 01 = 3x3 only; 10 = 1x1 only
- in_ch  in  9  input-channel count, 0..MAX_ICH
- och_idx  in  8  output channel being fetched
- base3 / base1  in  ADDR_W  3x3 / 1x1 weight region base byte addresses
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final response is written
- req_addr  out  ADDR_W  read byte address
- req_vld  out  1  request valid
- req_rdy  in  1  arbiter accepts
- rsp_data  in  DATA_W  read data
- rsp_vld  in  1  response valid, in request order
- rsp_rdy  out  1  constant 1
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  DATA_W  equals rsp_data
- wr_en  out  1  equals rsp_vld
- stall_cnt  out  16  present only with WFU_STALL_CNT_EN

## Operation
- CW = ceil(in_ch/WPW) words per kernel position; N3 = 9*CW, N1 = CW.
- FSM states: IDLE, REQ3, REQ1, DRAIN.
  - IDLE + start: latch all inputs and set busy. Go to REQ3 if mode != 10, else REQ1.
  - REQ3: after N3 accepted requests, go to REQ1 if mode != 01, else DRAIN.
  - REQ1: after N1 accepted requests, go to DRAIN.
  - DRAIN: stay until all expected responses arrive; pulse done, then go to IDLE.
- Start address: REQ3 begins at base3 + och_idx*N3*WPW; REQ1 begins at base1 + och_idx*N1*WPW. Each accepted request adds WPW to the address. Use ADDR_W-bit wrapping arithmetic.
- Credits: the outstanding count increments on accept and decrements on response. req_vld is forced low when outstanding == MAX_OUTST.
- Simultaneous accept and response in the same cycle leave the count unchanged.
- wr_addr layout:
  - [ADDR_W-1] = phase (0 = 3x3, 1 = 1x1)
  - [ADDR_W-2:ADDR_W-9] = och_idx
  - [11:8] = kernel position 0..8 (always 0 for 1x1)
  - [7:0] = word index within the position
  - all other bits 0
- The response counter advances the word index 0..CW-1, then wraps it to 0 and increments the kernel position. After the ninth 3x3 position it switches phase to 1x1.
- in_ch = 0: no requests are issued; done pulses 2 cycles after start.
- A start pulse while busy is ignored.
- A response received with 0 outstanding is dropped: no wr_en.

## Timing
- Reset values: all state and outputs 0, state IDLE.
- req_vld, req_addr, busy and done are registered. req_vld rises the cycle after start is accepted.
- Once req_vld is high, req_vld and req_addr hold until req_rdy. One request is accepted per cycle at most.
- wr_* is combinational from rsp_*, with zero latency.
- done follows the final wr_en by 1 cycle; busy falls in the same cycle that done is high.
- Reset asserted mid-operation returns to IDLE on the next clock edge. Responses still in flight after reset are dropped by the zero-outstanding rule.

## Configuration
- WFU_STALL_CNT_EN defined:
  - stall_cnt counts cycles with req_vld & !req_rdy while busy.
  - It clears on each accepted start and saturates at 0xFFFF.
- WFU_STALL_CNT_EN undefined: the stall_cnt port and its logic are absent.

## Structure
- Package wfu_pkg holds:
  - state enum
  - phase and mode encodings
  - localparams for the wr_addr field positions and the kernel-position count (9)
- Sub-module wfu_wr_addr_gen contains the response-side word, position and phase counters and produces wr_addr. The top level holds the FSM, request address and credits.

## Test plan
- in_ch=64, mode=00, och_idx=2, base3=0x1000, base1=0x8000, req_rdy=1, one-cycle response latency:
  - 144 requests starting at 0x1480, then 16 starting at 0x8080
  - 160 writes; done one cycle after the last write
- in_ch=20, mode=10: CW=5; 5 requests starting at base1 + och_idx*20; wr_addr phase=1, position 0, words 0..4.
- MAX_OUTST=8, responses withheld:
  - exactly 8 requests accepted, then req_vld stays low
  - each response releases exactly one further request
- req_rdy toggled randomly: req_addr is stable while stalled; with WFU_STALL_CNT_EN, stall_cnt equals the number of stalled cycles.
- Boundary cases:
  - start while busy: no effect
  - in_ch=0: done after 2 cycles with no requests
  - reset mid-REQ3: IDLE next cycle; late responses cause no wr_en

Source files
------------

// File: rtl/wfu_pkg.sv
// wfu_pkg: shared types and constants for the weight fetch unit.
//   - wfu_state_e : request-side FSM states
//   - wfu_phase_e : kernel phase (3x3 / 1x1), also the top bit of wr_addr
//   - MODE_*      : mode input encodings (00 and 11 both mean 3x3 then 1x1)
//   - WA_*        : field positions inside the weight-buffer write address
//   - KPOS        : number of kernel positions in a 3x3 kernel
package wfu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ3  = 2'd1,
    ST_REQ1  = 2'd2,
    ST_DRAIN = 2'd3
  } wfu_state_e;

  typedef enum logic {
    PH_3X3 = 1'b0,
    PH_1X1 = 1'b1
  } wfu_phase_e;

  localparam logic [1:0] MODE_3X3 = 2'b01;
  localparam logic [1:0] MODE_1X1 = 2'b10;

  localparam int KPOS       = 9;
  localparam int WA_WORD_LSB = 0;
  localparam int WA_WORD_W   = 8;
  localparam int WA_POS_LSB  = 8;
  localparam int WA_POS_W    = 4;
  localparam int WA_OCH_W    = 8;

endpackage

// File: rtl/wfu_if.sv
// wfu_if: read-request / read-response bus between the weight fetch unit
// and the memory arbiter.
//   req_addr/req_vld/req_rdy : word read request, byte address
//   rsp_data/rsp_vld/rsp_rdy : in-order read response
// Modports: master = fetch unit, slave = arbiter.
interface wfu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] req_addr;
  logic              req_vld;
  logic              req_rdy;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_vld;
  logic              rsp_rdy;

  modport master (
    output req_addr, req_vld, rsp_rdy,
    input  req_rdy, rsp_data, rsp_vld
  );

  modport slave (
    input  req_addr, req_vld, rsp_rdy,
    output req_rdy, rsp_data, rsp_vld
  );
endinterface

// File: rtl/wfu_wr_addr_gen.sv
// wfu_wr_addr_gen: response-side counters of the weight fetch unit.
// Tracks word index within a kernel position, kernel position and phase for
// each accepted response and forms the weight-buffer write address:
//   [ADDR_W-1]            phase (0 = 3x3, 1 = 1x1)
//   [ADDR_W-2:ADDR_W-9]   output channel
//   [11:8]                kernel position
//   [7:0]                 word index
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         start of a new job: clear counters, set initial phase
//   load_phase   phase the job starts in
//   och          latched output channel
//   cw           words per kernel position for the current job
//   adv          one response written this cycle
//   wr_addr      write address for the response currently presented
module wfu_wr_addr_gen
  import wfu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  wfu_phase_e            load_phase,
  input  logic [WA_OCH_W-1:0]   och,
  input  logic [8:0]            cw,
  input  logic                  adv,
  output logic [ADDR_W-1:0]     wr_addr
);

  logic [WA_WORD_W-1:0] word_q, word_d;
  logic [WA_POS_W-1:0]  pos_q, pos_d;
  wfu_phase_e           phase_q, phase_d;

  always_comb begin
    word_d  = word_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    if (load) begin
      word_d  = '0;
      pos_d   = '0;
      phase_d = load_phase;
    end else if (adv) begin
      if ({1'b0, word_q} + 9'd1 == cw) begin
        word_d = '0;
        // Only the 3x3 phase steps through kernel positions; the ninth
        // position rolls over into the 1x1 phase.
        if (phase_q == PH_3X3) begin
          if (pos_q == WA_POS_W'(KPOS - 1)) begin
            pos_d   = '0;
            phase_d = PH_1X1;
          end else begin
            pos_d = pos_q + WA_POS_W'(1);
          end
        end
      end else begin
        word_d = word_q + WA_WORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      pos_q   <= '0;
      phase_q <= PH_3X3;
    end else begin
      word_q  <= word_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    wr_addr = '0;
    wr_addr[ADDR_W-1]                          = phase_q;
    wr_addr[ADDR_W-2 -: WA_OCH_W]              = och;
    wr_addr[WA_POS_LSB +: WA_POS_W]            = pos_q;
    wr_addr[WA_WORD_LSB +: WA_WORD_W]          = word_q;
  end

endmodule

// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: fetches the 3x3 and/or 1x1 kernel weights of one output
// channel from the memory arbiter and writes them into the MAC-array weight
// buffer.
// Parameters: DATA_W (bus width, DATA_W/8 int8 weights per word), ADDR_W,
//   MAX_ICH (largest input-channel count), MAX_OUTST (read credit limit).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                one-cycle start, honoured only when idle
//   mode                 00/11 3x3 then 1x1, 01 3x3 only, 10 1x1 only
//   in_ch, och_idx       input-channel count, output channel
//   base3, base1         3x3 / 1x1 weight region byte base addresses
//   busy, done           job in progress / one-cycle completion pulse
//   wr_addr/wr_data/wr_en weight-buffer write port (combinational from rsp)
//   bus                  wfu_if master: read requests and responses
//   stall_cnt            cycles of stalled requests; present only when
//                        WFU_STALL_CNT_EN is defined
module weight_fetch_unit
  import wfu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_ICH   = 256,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [8:0]        in_ch,
  input  logic [7:0]        och_idx,
  input  logic [ADDR_W-1:0] base3,
  input  logic [ADDR_W-1:0] base1,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  wfu_if.master             bus
`ifdef WFU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int WPW   = DATA_W / 8;
  localparam int CNT_W = $clog2(KPOS * MAX_ICH + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  wfu_state_e        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        och_q, och_d;
  logic [8:0]        cw_q, cw_d;
  logic [ADDR_W-1:0] base1_q, base1_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_vld_q, req_vld_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              accept;
  logic              rsp_take;
  logic [8:0]        cw_in;
  logic [CNT_W-1:0]  n3, n1;
  wfu_phase_e        load_phase;

  function automatic logic [ADDR_W-1:0] start_addr(
    input logic [ADDR_W-1:0] base,
    input logic [7:0]        och,
    input logic [CNT_W-1:0]  nwords
  );
    return base + ADDR_W'(och) * ADDR_W'(nwords) * ADDR_W'(WPW);
  endfunction

  assign start_ok = start && (state_q == ST_IDLE);
  assign accept   = req_vld_q && bus.req_rdy;
  // A response with no read outstanding (e.g. one left over from before a
  // reset) has no owner and is dropped.
  assign rsp_take = bus.rsp_vld && (outst_q != '0);

  assign cw_in = 9'((10'(in_ch) + 10'(WPW - 1)) / 10'(WPW));
  assign n3    = CNT_W'(KPOS) * CNT_W'(cw_q);
  assign n1    = CNT_W'(cw_q);

  assign load_phase = (mode == MODE_1X1) ? PH_1X1 : PH_3X3;

  always_comb begin
    outst_d = outst_q;
    case ({accept, rsp_take})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    och_d      = och_q;
    cw_d       = cw_q;
    base1_d    = base1_q;
    req_addr_d = req_addr_q;
    req_cnt_d  = req_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          och_d     = och_idx;
          cw_d      = cw_in;
          base1_d   = base1;
          busy_d    = 1'b1;
          req_cnt_d = '0;
          // An empty job goes straight to DRAIN, which finishes at once.
          if (in_ch == '0) begin
            state_d = ST_DRAIN;
          end else if (mode == MODE_1X1) begin
            state_d    = ST_REQ1;
            req_addr_d = start_addr(base1, och_idx, CNT_W'(cw_in));
          end else begin
            state_d    = ST_REQ3;
            req_addr_d = start_addr(base3, och_idx, CNT_W'(KPOS) * CNT_W'(cw_in));
          end
        end
      end

      ST_REQ3: begin
        if (accept) begin
          if (req_cnt_q + CNT_W'(1) == n3) begin
            req_cnt_d = '0;
            if (mode_q != MODE_3X3) begin
              state_d    = ST_REQ1;
              req_addr_d = start_addr(base1_q, och_q, n1);
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            req_cnt_d  = req_cnt_q + CNT_W'(1);
            req_addr_d = req_addr_q + ADDR_W'(WPW);
          end
        end
      end

      ST_REQ1: begin
        if (accept) begin
          if (req_cnt_q + CNT_W'(1) == n1) begin
            req_cnt_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            req_cnt_d  = req_cnt_q + CNT_W'(1);
            req_addr_d = req_addr_q + ADDR_W'(WPW);
          end
        end
      end

      ST_DRAIN: begin
        // Finish in the cycle of the last write so done lands one cycle later.
        if ((outst_q == '0) || ((outst_q == OUT_W'(1)) && rsp_take)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A pending request keeps its credit (outst_d never grows without an
    // accept), so a stalled req_vld stays high with its address held.
    req_vld_d = ((state_d == ST_REQ3) || (state_d == ST_REQ1)) &&
                (outst_d < OUT_W'(MAX_OUTST));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      och_q      <= '0;
      cw_q       <= '0;
      base1_q    <= '0;
      req_addr_q <= '0;
      req_vld_q  <= 1'b0;
      req_cnt_q  <= '0;
      outst_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      och_q      <= och_d;
      cw_q       <= cw_d;
      base1_q    <= base1_d;
      req_addr_q <= req_addr_d;
      req_vld_q  <= req_vld_d;
      req_cnt_q  <= req_cnt_d;
      outst_q    <= outst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  wfu_wr_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_wr_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_ok),
    .load_phase (load_phase),
    .och        (och_q),
    .cw         (cw_q),
    .adv        (rsp_take),
    .wr_addr    (wr_addr)
  );

`ifdef WFU_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if (busy_q && req_vld_q && !bus.req_rdy && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.req_addr = req_addr_q;
  assign bus.req_vld  = req_vld_q;
  assign bus.rsp_rdy  = 1'b1;
  assign wr_en        = rsp_take;
  assign wr_data      = bus.rsp_data;

endmodule
